// File: rtl/ysyx_25040118_imem_resp_pkg.sv
// rtl/ysyx_25040118_imem_resp_pkg.sv - shared types and constants for the instruction-memory responder
package ysyx_25040118_imem_resp_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  // Addresses below the base wrap to a huge offset, so one compare covers both ends.
  function automatic logic fetch_err(logic [31:0] addr, logic [31:0] off, int unsigned depth);
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= (33'(depth) << 2));
  endfunction

endpackage

// File: rtl/ysyx_25040118_imem_resp_if.sv
// rtl/ysyx_25040118_imem_resp_if.sv - fetch request/response and preload bundle
interface ysyx_25040118_imem_resp_if #(
  parameter int DEPTH = 1024
);
  import ysyx_25040118_imem_resp_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [INST_W-1:0] rsp_data;
  logic              rsp_err;
  logic              load_en;
  logic [IDX_W-1:0]  load_idx;
  logic [INST_W-1:0] load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/ysyx_25040118_imem_array.sv
// rtl/ysyx_25040118_imem_array.sv - synchronous-write, asynchronous-read instruction word array
module ysyx_25040118_imem_array
  import ysyx_25040118_imem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [INST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [INST_W-1:0] rdata
);

  // No reset: program contents survive a responder reset.
  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_25040118_imem_resp.sv
// rtl/ysyx_25040118_imem_resp.sv - instruction-memory responder with programmable fetch latency
module ysyx_25040118_imem_resp
  import ysyx_25040118_imem_resp_pkg::*;
#(
  parameter logic [31:0] BASE    = RESET_PC,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  ysyx_25040118_imem_resp_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  imem_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [INST_W-1:0] data_q, data_nxt;
  logic              err_q, err_nxt;

  logic [31:0]       off;
  logic [IDX_W-1:0]  ridx;
  logic [INST_W-1:0] rdata;
  logic              err;

  assign off  = bus.req_addr - BASE;
  assign ridx = off[2 +: IDX_W];
  assign err  = fetch_err(bus.req_addr, off, DEPTH);

  // Read is sampled at the accepting edge, so a same-edge preload returns the old word.
  ysyx_25040118_imem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (bus.load_en),
    .widx  (bus.load_idx),
    .wdata (bus.load_data),
    .ridx  (ridx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          data_nxt = err ? '0 : rdata;
          err_nxt  = err;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_W'(LATENCY - 2);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25040118_imem_resp.sv
// tb/tb_ysyx_25040118_imem_resp.sv - scoreboard bench for the instruction-memory responder
module tb_ysyx_25040118_imem_resp;
  import ysyx_25040118_imem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] load_data = '0;
  logic [9:0]  load_idx = '0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  ysyx_25040118_imem_resp_if #(.DEPTH(1024)) if1 ();
  ysyx_25040118_imem_resp_if #(.DEPTH(1024)) if4 ();

  assign if1.req_valid = req_valid & ~sel;
  assign if1.req_addr  = req_addr;
  assign if1.rsp_ready = rsp_ready & ~sel;
  assign if1.load_en   = load_en;
  assign if1.load_idx  = load_idx;
  assign if1.load_data = load_data;
  assign if4.req_valid = req_valid & sel;
  assign if4.req_addr  = req_addr;
  assign if4.rsp_ready = rsp_ready & sel;
  assign if4.load_en   = load_en;
  assign if4.load_idx  = load_idx;
  assign if4.load_data = load_data;

  ysyx_25040118_imem_resp #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  ysyx_25040118_imem_resp #(.LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  wire        o_req_ready = sel ? if4.req_ready : if1.req_ready;
  wire        o_rsp_valid = sel ? if4.rsp_valid : if1.rsp_valid;
  wire [31:0] o_rsp_data  = sel ? if4.rsp_data  : if1.rsp_data;
  wire        o_rsp_err   = sel ? if4.rsp_err   : if1.rsp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] expect_rsp(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    if (addr[1:0] != 2'b00 || off >= 32'd4096) return {1'b1, 32'h0};
    return {1'b0, model[off[11:2]]};
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_idx  = idx[9:0];
    load_data = d;
    model[idx] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr);
    check("req_ready_idle", o_req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    sb.push_back(expect_rsp(addr));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int lat, input int stall, input bit next_v, input logic [31:0] next_a);
    int          w;
    logic [31:0] d0;
    logic        e0;
    logic [32:0] exp;
    w = 0;
    while (o_rsp_valid !== 1'b1 && w < 20) begin
      check("req_ready_wait", o_req_ready, 0);
      @(negedge clk);
      w++;
    end
    check("latency", w, 32'(lat - 1));
    if (o_rsp_valid !== 1'b1) return;
    d0 = o_rsp_data;
    e0 = o_rsp_err;
    if (next_v) begin
      req_valid = 1'b1;
      req_addr  = next_a;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", o_rsp_valid, 1);
      check("stall_data", o_rsp_data, d0);
      check("stall_err", o_rsp_err, e0);
      check("stall_req_ready", o_req_ready, 0);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 33'hx;
    check("rsp_data", o_rsp_data, exp[31:0]);
    check("rsp_err", o_rsp_err, exp[32]);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", o_rsp_valid, 0);
    check("req_ready_back", o_req_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    load(0, 32'h0000_0297);
    load(1, 32'h0082_8293);
    load(1023, 32'hDEAD_BEEF);
    load(5, 32'hAAAA_AAAA);
    reset = 1'b1;
    @(negedge clk);

    check("rst_req_ready1", if1.req_ready, 1);
    check("rst_rsp_valid1", if1.rsp_valid, 0);
    check("rst_rsp_data1", if1.rsp_data, 0);
    check("rst_rsp_err1", if1.rsp_err, 0);
    check("rst_req_ready4", if4.req_ready, 1);
    check("rst_rsp_valid4", if4.rsp_valid, 0);

    issue(32'h8000_0000); collect(1, 0, 0, 0);
    issue(32'h8000_0004); collect(1, 0, 0, 0);

    issue(32'h8000_0002); collect(1, 0, 0, 0);
    issue(32'h8000_1000); collect(1, 0, 0, 0);
    issue(32'h7FFF_FFFC); collect(1, 0, 0, 0);
    issue(32'h8000_0FFC); collect(1, 0, 0, 0);

    // Fetch and preload of the same word on one edge.
    check("req_ready_sim", o_req_ready, 1);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0014;
    sb.push_back(expect_rsp(32'h8000_0014));
    load_en   = 1'b1;
    load_idx  = 10'd5;
    load_data = 32'h5555_5555;
    model[5]  = 32'h5555_5555;
    @(negedge clk);
    req_valid = 1'b0;
    load_en   = 1'b0;
    collect(1, 0, 0, 0);
    issue(32'h8000_0014); collect(1, 0, 0, 0);

    sel = 1'b1;
    issue(32'h8000_0000); collect(4, 5, 1, 32'h8000_0004);
    issue(32'h8000_0004); collect(4, 0, 0, 0);

    issue(32'h8000_0000);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      check("abort_rsp_valid", o_rsp_valid, 0);
      check("abort_req_ready", o_req_ready, 1);
      @(negedge clk);
    end
    issue(32'h8000_0004); collect(4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040118_imem_resp.md
Name: ysyx_25040118_imem_resp

Overview:
- Instruction-memory responder: the other end of the fetch interface driven by the PC register in the IFU.
- Accepts one fetch request (byte address) over a valid/ready handshake.
- Returns the 32-bit instruction word after a programmable latency over a valid/ready response channel.
- Holds the program in an internal word array, preloaded through a side write port, and flags misaligned or out-of-range fetches.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0; matches the IFU reset PC.
- DEPTH, 1024, number of 32-bit words (power of 2, ≥2).
- LATENCY, 1, cycles from request accept to rsp_valid (≥1).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset: reset==0 at a posedge resets.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (the PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  instruction word; 0 when rsp_err.
- rsp_err  out  1  misaligned or out-of-range fetch.
- load_en  in  1  preload write strobe.
- load_idx  in  $clog2(DEPTH)  preload word index.
- load_data  in  32  preload word.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; req_ready=1 in the following cycle.
  - rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - Accept = req_valid&&req_ready at a posedge.
  - On accept: compute off=req_addr-BASE (32-bit, wraps) and idx=off[2+:log2(DEPTH)].
  - err=(req_addr[1:0]!=0) || (off >= DEPTH*4).
  - Latch rsp_err=err and rsp_data = err ? 0 : mem[idx].
  - LATENCY==1: go to RESP. Otherwise load cnt=LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - If cnt==0, go to RESP; else cnt-=1.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready at a posedge, then go to IDLE.
  - A stalled rsp_ready holds indefinitely.
- Latency: accept at posedge N gives rsp_valid high from posedge N+LATENCY.
- Throughput: at most one request per LATENCY+1 cycles; no request overlap.
- Read data is captured at accept.
- Preload:
  - load_en writes mem[load_idx]=load_data at posedge, in any state.
  - A load to the same index in the same cycle as accept returns the old word (read-before-write).
  - A later load does not alter an in-flight response.
- req_addr and req_valid are ignored when req_ready=0. The requester must hold req_valid/req_addr until accepted.
- Reset mid-WAIT or mid-RESP aborts the transaction; no response is produced.
- load_en during reset still writes (array has no reset).
- Out-of-range includes addresses below BASE, which wrap to a large off.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - RESET_PC constant 32'h8000_0000, used for BASE and by the IFU.
  - Instruction width 32.
- One natural sub-module: ysyx_25040118_imem_array.
  - Synchronous-write, asynchronous-read word array.
  - Ports: clk, we, widx, wdata, ridx, rdata.
  - FSM, counter and error check stay in the top module.

Test Plan:
- Reset and preload:
  - Stimulus: hold reset=0 for 2 cycles; preload mem[0]=32'h0000_0297, mem[1]=32'h0082_8293; release; request 0x8000_0000 with rsp_ready=1, LATENCY=1.
  - Required: req_ready=1 after reset; rsp_valid the cycle after accept; rsp_data=32'h0000_0297, rsp_err=0; next request 0x8000_0004 returns 32'h0082_8293.
- Latency:
  - Stimulus: LATENCY=4, accept at cycle 10.
  - Required: rsp_valid=0 for cycles 11-13 and 1 at 14; req_ready=0 from 11 until the response handshake.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises; a new req_valid is asserted meanwhile.
  - Required: rsp_data/rsp_err stable, req_ready=0, new request not accepted; on rsp_ready=1, IDLE next cycle, then the request is accepted.
- Errors:
  - Stimulus: requests to 0x8000_0002, 0x8000_1000 (DEPTH=1024) and 0x7FFF_FFFC.
  - Required: each gives rsp_err=1, rsp_data=0; 0x8000_0FFC gives rsp_err=0 with the mem[1023] value.
- Simultaneous load/fetch:
  - Stimulus: mem[5]=32'hAAAA_AAAA; accept 0x8000_0014 in the same cycle as load_idx=5, load_data=32'h5555_5555.
  - Required: response 32'hAAAA_AAAA; the next fetch of the same address returns 32'h5555_5555.
- Reset mid-operation:
  - Stimulus: LATENCY=4, assert reset=0 one cycle after accept for 1 cycle.
  - Required: no rsp_valid pulse; state IDLE with req_ready=1 after release; preloaded contents intact.
